// File: rtl/seq_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_array_multiplier
// Purpose  : Iterative radix-2 shift-add multiplier with a valid/ready
//            handshake on each side. It resolves one partial product per
//            clock, so a result takes WIDTH cycles.
//            Define SIGNED_MULT_EN to add the sgn port and two's-complement
//            operation.
// Revision : 1.0 - initial release
// ============================================================================
module seq_array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef SIGNED_MULT_EN
    input  logic                 sgn,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      count_q, count_d;

    logic               last_iter;
    logic [WIDTH:0]     hi_ext;
    logic [WIDTH:0]     mc_ext;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   wide;
    logic [2*WIDTH-1:0] shifted;

    assign last_iter = (count_q == CW'(WIDTH - 1));

`ifdef SIGNED_MULT_EN
    logic sgn_q, sgn_d;

    // In signed mode the top operand bit carries negative weight, so the
    // final partial product is subtracted rather than added.
    always_comb begin
        hi_ext = {sgn_q & acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
        mc_ext = {sgn_q & mcand_q[WIDTH-1], mcand_q};
        sum    = hi_ext;
        if (acc_q[0]) begin
            if (sgn_q && last_iter) begin
                sum = hi_ext - mc_ext;
            end else begin
                sum = hi_ext + mc_ext;
            end
        end
    end
`else
    always_comb begin
        hi_ext = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        mc_ext = {1'b0, mcand_q};
        sum    = acc_q[0] ? (hi_ext + mc_ext) : hi_ext;
    end
`endif

    // The extra sum bit (carry or sign) becomes the new accumulator MSB.
    assign wide    = {sum, acc_q[WIDTH-1:0]};
    assign shifted = wide[2*WIDTH:1];

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        p_d     = p_q;
        count_d = count_q;
`ifdef SIGNED_MULT_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = x;
                    acc_d   = {{WIDTH{1'b0}}, y};
                    count_d = '0;
`ifdef SIGNED_MULT_EN
                    sgn_d   = sgn;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d   = shifted;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    p_d     = shifted;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            count_q <= '0;
`ifdef SIGNED_MULT_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            count_q <= count_d;
`ifdef SIGNED_MULT_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign p         = p_q;

endmodule
`default_nettype wire
